// File: rtl/hit_judge_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hit_judge_pkg
// Brief   : Grade encoding, note-slot states and default timing windows for
//           the rhythm-game hit judge.
// Revision: 1.0 - initial release
// ============================================================================
package hit_judge_pkg;

  // Grade encoding must match what the downstream score accumulator decodes.
  typedef enum logic [1:0] {
    GRADE_BAD    = 2'b00,
    GRADE_NORMAL = 2'b01,
    GRADE_NICE   = 2'b10,
    GRADE_GREAT  = 2'b11
  } grade_t;

  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_ARMED = 1'b1
  } slot_t;

  localparam int c_def_time_w     = 16;
  localparam int c_def_great_win  = 20;
  localparam int c_def_nice_win   = 50;
  localparam int c_def_normal_win = 100;
  localparam int c_def_bad_win    = 150;

endpackage : hit_judge_pkg
`default_nettype wire

// File: rtl/hit_judge_btn_sync_edge.sv
`default_nettype none
// ============================================================================
// Module  : btn_sync_edge
// Brief   : Two-flop synchroniser for an asynchronous button level followed by
//           a single-cycle rising-edge pulse.
// Revision: 1.0 - initial release
// ============================================================================
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= async_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  // A held button yields exactly one pulse, on the cycle it first appears synced.
  assign rise_pulse = r_sync & ~r_prev;

endmodule : btn_sync_edge
`default_nettype wire

// File: rtl/hit_judge.sv
`default_nettype none
// ============================================================================
// Module  : hit_judge
// Brief   : Run-gated millisecond timer, single pending note slot, and timing
//           judgment of button presses and missed notes into a graded pulse.
// Revision: 1.0 - initial release
// ============================================================================
module hit_judge
  import hit_judge_pkg::*;
#(
  parameter int TIME_W     = c_def_time_w,
  parameter int GREAT_WIN  = c_def_great_win,
  parameter int NICE_WIN   = c_def_nice_win,
  parameter int NORMAL_WIN = c_def_normal_win,
  parameter int BAD_WIN    = c_def_bad_win
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_ms,
  input  logic              run,
  input  logic              btn_raw,
  input  logic              note_valid,
  input  logic [TIME_W-1:0] note_time,
  output logic              note_ready,
  output logic [TIME_W-1:0] now_ms,
  output logic              triggered_point,
  output logic [1:0]        triggered_state
);

  // Two extra bits keep the difference of two unsigned times exact.
  localparam int c_d_w = TIME_W + 2;

  localparam logic [c_d_w-1:0] c_great  = c_d_w'(GREAT_WIN);
  localparam logic [c_d_w-1:0] c_nice   = c_d_w'(NICE_WIN);
  localparam logic [c_d_w-1:0] c_normal = c_d_w'(NORMAL_WIN);
  localparam logic [c_d_w-1:0] c_bad    = c_d_w'(BAD_WIN);

  logic [TIME_W-1:0] r_now;
  logic [TIME_W-1:0] r_target;
  slot_t             r_slot;
  slot_t             w_slot_nxt;
  logic              r_point;
  grade_t            r_state;

  logic              w_press;
  logic              w_sat;
  logic [c_d_w-1:0]  w_d;
  logic              w_neg;
  logic [c_d_w-1:0]  w_mag;
  logic              w_in_window;
  logic              w_early_bad;
  logic              w_late;
  logic              w_fire;
  grade_t            w_grade;

  btn_sync_edge u_btn (
    .clk        (clk),
    .rst        (rst),
    .async_in   (btn_raw),
    .rise_pulse (w_press)
  );

  assign w_sat = &r_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_now <= '0;
    end else if (run && tick_ms && !w_sat) begin
      r_now <= r_now + TIME_W'(1);
    end
  end

  assign w_d   = {2'b00, r_now} - {2'b00, r_target};
  assign w_neg = w_d[c_d_w-1];
  assign w_mag = w_neg ? -w_d : w_d;

  assign w_in_window = (w_mag <= c_normal);
  assign w_early_bad = w_neg && (w_mag > c_normal) && (w_mag <= c_bad);
  assign w_late      = !w_neg && (w_mag > c_normal);

  always_comb begin
    w_slot_nxt = r_slot;
    w_fire     = 1'b0;
    w_grade    = GRADE_BAD;
    case (r_slot)
      SLOT_EMPTY: begin
        if (note_valid) begin
          w_slot_nxt = SLOT_ARMED;
        end
      end
      SLOT_ARMED: begin
        if (run) begin
          // A press on the same cycle as a miss is judged as a press.
          if (w_press && w_in_window) begin
            w_fire = 1'b1;
            if (w_mag <= c_great) begin
              w_grade = GRADE_GREAT;
            end else if (w_mag <= c_nice) begin
              w_grade = GRADE_NICE;
            end else begin
              w_grade = GRADE_NORMAL;
            end
          end else if (w_press && (w_early_bad || w_late)) begin
            w_fire = 1'b1;
          end else if (w_late || w_sat) begin
            // A saturated timer can never pass a late target, so it forces the miss.
            w_fire = 1'b1;
          end
          if (w_fire) begin
            w_slot_nxt = SLOT_EMPTY;
          end
        end
      end
      default: begin
        w_slot_nxt = SLOT_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot   <= SLOT_EMPTY;
      r_target <= '0;
      r_point  <= 1'b0;
      r_state  <= GRADE_BAD;
    end else begin
      r_slot  <= w_slot_nxt;
      r_point <= w_fire;
      if (r_slot == SLOT_EMPTY && note_valid) begin
        r_target <= note_time;
      end
      if (w_fire) begin
        r_state <= w_grade;
      end
    end
  end

  assign note_ready      = (r_slot == SLOT_EMPTY);
  assign now_ms          = r_now;
  assign triggered_point = r_point;
  assign triggered_state = r_state;

endmodule : hit_judge
`default_nettype wire

// File: tb/tb_hit_judge.sv
`default_nettype none
// ============================================================================
// Module  : tb_hit_judge
// Brief   : Directed self-checking bench for hit_judge with default windows.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hit_judge;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick_ms;
  logic        run;
  logic        btn_raw;
  logic        note_valid;
  logic [15:0] note_time;
  logic        note_ready;
  logic [15:0] now_ms;
  logic        triggered_point;
  logic [1:0]  triggered_state;

  int checks   = 0;
  int failures = 0;

  int          cyc       = 0;
  int          pulse_cnt = 0;
  int          last_cyc  = 0;
  int          last_gap  = 0;
  int          min_gap   = 1000;
  logic [1:0]  last_state;
  logic        last_ready;
  logic [15:0] last_now;
  int          exp_now;
  int          press_cyc;

  hit_judge dut (
    .clk             (clk),
    .rst             (rst),
    .tick_ms         (tick_ms),
    .run             (run),
    .btn_raw         (btn_raw),
    .note_valid      (note_valid),
    .note_time       (note_time),
    .note_ready      (note_ready),
    .now_ms          (now_ms),
    .triggered_point (triggered_point),
    .triggered_state (triggered_state)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled 2 ns after each rising edge.
  always @(posedge clk) begin
    cyc++;
    #2;
    if (triggered_point === 1'b1) begin
      if (pulse_cnt > 0) begin
        last_gap = cyc - last_cyc;
        if (last_gap < min_gap) min_gap = last_gap;
      end
      last_cyc   = cyc;
      last_state = triggered_state;
      last_ready = note_ready;
      last_now   = now_ms;
      pulse_cnt++;
    end
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(negedge clk) tick_ms = 1'b1;
      @(negedge clk) tick_ms = 1'b0;
      repeat (2) @(negedge clk);
      if (run) exp_now++;
    end
  endtask

  task automatic advance_to(input int t);
    tick_n(t - exp_now);
  endtask

  task automatic offer(input int t);
    @(negedge clk);
    note_valid = 1'b1;
    note_time  = t[15:0];
    @(negedge clk);
    note_valid = 1'b0;
  endtask

  task automatic press();
    @(negedge clk);
    btn_raw   = 1'b1;
    press_cyc = cyc;
    repeat (6) @(negedge clk);
    btn_raw = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    tick_ms    = 1'b0;
    run        = 1'b1;
    btn_raw    = 1'b0;
    note_valid = 1'b0;
    note_time  = '0;
    repeat (3) @(negedge clk);
    rst     = 1'b0;
    exp_now = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (now_ms !== 16'd0) begin failures++; $display("FAIL reset_now got=%0d want=0", now_ms); end
    checks++; if (note_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", note_ready); end
    checks++; if (triggered_point !== 1'b0) begin failures++; $display("FAIL reset_point got=%b want=0", triggered_point); end
    checks++; if (triggered_state !== 2'b00) begin failures++; $display("FAIL reset_state got=%b want=00", triggered_state); end
  endtask

  // Ascending press times against a target of 1000 ms; hand-graded.
  task automatic test_windows();
    int         t_now [17] = '{800, 849, 850, 880, 899, 900, 950, 960, 979, 980,
                               1010, 1020, 1021, 1050, 1051, 1090, 1100};
    logic       t_hit [17] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    logic [1:0] t_grd [17] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10,
                               2'b10, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01};
    int p0;
    do_reset();
    offer(1000);
    checks++; if (note_ready !== 1'b0) begin failures++; $display("FAIL armed_ready got=%b want=0", note_ready); end
    for (int i = 0; i < 17; i++) begin
      advance_to(t_now[i]);
      p0 = pulse_cnt;
      press();
      checks++; if (now_ms !== t_now[i][15:0]) begin failures++; $display("FAIL win_now[%0d] got=%0d want=%0d", i, now_ms, t_now[i]); end
      checks++; if (pulse_cnt - p0 !== int'(t_hit[i])) begin failures++; $display("FAIL win_pulses@%0d got=%0d want=%0d", t_now[i], pulse_cnt - p0, t_hit[i]); end
      if (t_hit[i]) begin
        checks++; if (last_state !== t_grd[i]) begin failures++; $display("FAIL win_grade@%0d got=%b want=%b", t_now[i], last_state, t_grd[i]); end
        checks++; if (last_ready !== 1'b1) begin failures++; $display("FAIL win_ready_at_pulse@%0d got=%b want=1", t_now[i], last_ready); end
        checks++; if (last_cyc - press_cyc < 3 || last_cyc - press_cyc > 4) begin failures++; $display("FAIL win_latency@%0d got=%0d want=3..4", t_now[i], last_cyc - press_cyc); end
        offer(1000);
      end else begin
        checks++; if (note_ready !== 1'b0) begin failures++; $display("FAIL win_still_armed@%0d got=%b want=0", t_now[i], note_ready); end
      end
    end
  endtask

  task automatic test_miss();
    int p0;
    do_reset();
    offer(1000);
    advance_to(1100);
    p0 = pulse_cnt;
    repeat (8) @(negedge clk);
    checks++; if (pulse_cnt !== p0) begin failures++; $display("FAIL miss_early got=%0d want=0 pulses at 1100", pulse_cnt - p0); end
    tick_n(1);
    checks++; if (pulse_cnt !== p0 + 1) begin failures++; $display("FAIL miss_pulses got=%0d want=1", pulse_cnt - p0); end
    checks++; if (last_state !== 2'b00) begin failures++; $display("FAIL miss_grade got=%b want=00", last_state); end
    checks++; if (last_now !== 16'd1101) begin failures++; $display("FAIL miss_now got=%0d want=1101", last_now); end
    checks++; if (last_ready !== 1'b1) begin failures++; $display("FAIL miss_ready got=%b want=1", last_ready); end
  endtask

  task automatic test_held();
    int p0;
    do_reset();
    offer(1000);
    advance_to(990);
    p0 = pulse_cnt;
    @(negedge clk) btn_raw = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (pulse_cnt !== p0 + 1) begin failures++; $display("FAIL held_first got=%0d want=1", pulse_cnt - p0); end
    checks++; if (last_state !== 2'b11) begin failures++; $display("FAIL held_grade got=%b want=11", last_state); end
    offer(1000);
    tick_n(500);
    checks++; if (pulse_cnt !== p0 + 2) begin failures++; $display("FAIL held_total got=%0d want=2", pulse_cnt - p0); end
    checks++; if (last_state !== 2'b00) begin failures++; $display("FAIL held_miss_grade got=%b want=00", last_state); end
    checks++; if (last_now !== 16'd1101) begin failures++; $display("FAIL held_miss_now got=%0d want=1101", last_now); end
    btn_raw = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_freeze_and_rst();
    int p0;
    do_reset();
    offer(1000);
    advance_to(990);
    @(negedge clk) run = 1'b0;
    p0 = pulse_cnt;
    tick_n(50);
    press();
    tick_n(50);
    checks++; if (now_ms !== 16'd990) begin failures++; $display("FAIL frz_now got=%0d want=990", now_ms); end
    checks++; if (pulse_cnt !== p0) begin failures++; $display("FAIL frz_pulse got=%0d want=0", pulse_cnt - p0); end
    checks++; if (note_ready !== 1'b0) begin failures++; $display("FAIL frz_retained got=%b want=0", note_ready); end
    @(negedge clk) run = 1'b1;
    press();
    checks++; if (pulse_cnt !== p0 + 1 || last_state !== 2'b11) begin failures++; $display("FAIL frz_resume got=%0d/%b want=1/11", pulse_cnt - p0, last_state); end
    @(negedge clk) run = 1'b0;
    offer(1000);
    checks++; if (note_ready !== 1'b0) begin failures++; $display("FAIL frz_accept got=%b want=0", note_ready); end
    // Reset lands on the cycle the press would be judged.
    @(negedge clk) run = 1'b1;
    p0 = pulse_cnt;
    @(negedge clk) btn_raw = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst     = 1'b0;
    btn_raw = 1'b0;
    exp_now = 0;
    repeat (6) @(negedge clk);
    checks++; if (pulse_cnt !== p0) begin failures++; $display("FAIL rst_pulse got=%0d want=0", pulse_cnt - p0); end
    checks++; if (now_ms !== 16'd0) begin failures++; $display("FAIL rst_now got=%0d want=0", now_ms); end
    checks++; if (note_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b want=1", note_ready); end
    checks++; if (triggered_state !== 2'b00) begin failures++; $display("FAIL rst_state got=%b want=00", triggered_state); end
  endtask

  task automatic test_back_to_back();
    int p0;
    bit seen;
    do_reset();
    offer(1000);
    advance_to(1100);
    p0 = pulse_cnt;
    @(negedge clk);
    note_valid = 1'b1;
    note_time  = 16'd500;
    tick_ms    = 1'b1;
    @(negedge clk) tick_ms = 1'b0;
    exp_now++;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (triggered_point === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL b2b_timeout got=no_pulse want=pulse"); end
    @(negedge clk) note_valid = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (pulse_cnt !== p0 + 2) begin failures++; $display("FAIL b2b_pulses got=%0d want=2", pulse_cnt - p0); end
    checks++; if (last_gap !== 2) begin failures++; $display("FAIL b2b_gap got=%0d want=2", last_gap); end
    checks++; if (last_state !== 2'b00 || note_ready !== 1'b1) begin failures++; $display("FAIL b2b_end got=%b/%b want=00/1", last_state, note_ready); end
  endtask

  initial begin
    rst        = 1'b1;
    tick_ms    = 1'b0;
    run        = 1'b0;
    btn_raw    = 1'b0;
    note_valid = 1'b0;
    note_time  = '0;
    exp_now    = 0;
    test_reset();
    test_windows();
    test_miss();
    test_held();
    test_freeze_and_rst();
    test_back_to_back();
    checks++; if (min_gap < 2) begin failures++; $display("FAIL pulse_spacing got=%0d want>=2", min_gap); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_hit_judge
`default_nettype wire
